processor_integration_5: RTL and testbench
==========================================

PROCESSOR_INTEGRATION_5 -- requirements
Module: processor_integration_5

Interface
REQ-001 SHALL have: Clock  in  1  single clock; all state updates on rising edge.
REQ-002 SHALL have: Reset  in  1  synchronous, active-low reset, sampled on rising Clock edge.
REQ-003 SHALL have: Data_In  in  16  instruction word for IR; IR_Write  in  1  IR load enable.
REQ-004 SHALL have: M_Data_In  in  16  memory read data; Mwrite  in  1  MDR load enable.
REQ-005 SHALL have: Asel, Bsel, ItypeSel  in  1 each  operand/immediate selects; Awrite, Bwrite  in  1 each  A/B load enables.
REQ-006 SHALL have: ALUcontrol  in  3  ALU op; ALUOutWrite  in  1  ALUOut load enable; iszero_write  in  1  zero-flag load enable.
REQ-007 SHALL have: reg_write  in  1  register-file write enable; destAddr  in  2  register-file index; destData  in  3  write-data select.
REQ-008 SHALL have: jControl  in  2  next-PC select; PCWrite  in  1  PC load enable; toPC  in  1  force Set_PC; Set_PC  in  16  PC override value.
REQ-009 SHALL have outputs: A, B, IR, ALUOut_output, PC_Out, PCData (16 each), isZero, overflow_out (1 each).

Function
REQ-010 Registers: IR, MDR, A, B, ALUOut, PC (16-bit), isZero flag, register file RF[0..3] (16-bit); each loads only when its enable is 1.
REQ-011 Imm = ItypeSel ? {IR[7:0],8'h00} : sign-extend(IR[11:0]).
REQ-012 A input: Asel=0 -> Imm; Asel=1 -> RF[destAddr].
REQ-013 B input: Bsel=1 -> Imm; Bsel=0 -> RF[IR[11:10]].
REQ-014 ALU (combinational, on A,B): 0 AND, 1 ADD, 2 SUB (A-B), 3 OR, 4 XOR, 5 A<<B[3:0], 6 A>>B[3:0] logical, 7 SLT signed (result 1/0); 16-bit wrap-around.
REQ-015 overflow_out combinational = two's-complement signed overflow of ADD/SUB; 0 for all other ops.
REQ-016 ALUOutWrite loads ALU result into ALUOut; iszero_write loads (ALU result == 0) into isZero.
REQ-017 RF write data by destData: 0 ALUOut, 1 MDR, 2 Imm, 3 A, 4 B, 5 PC_Out, 6 IR, 7 {15'b0,isZero}; written to RF[destAddr] when reg_write=1.
REQ-018 Jump mux by jControl: 0 PC+1; 1 PC + sign-extend(IR[11:0]); 2 {PC[15:12],IR[11:0]}; 3 ALUOut.
REQ-019 PCData = toPC ? Set_PC : jump-mux output (combinational); PC loads PCData when PCWrite=1; toPC without PCWrite has no effect.
REQ-020 All reads use pre-edge register values; a same-cycle RF write and A/B load yields the old RF value in A/B.
REQ-021 PC arithmetic wraps modulo 2^16 (0xFFFF+1 -> 0x0000).
REQ-022 Outputs A, B, IR, ALUOut_output, PC_Out, isZero SHALL directly reflect their registers.

Reset
REQ-023 When Reset=0 at a rising edge: PC, IR, MDR, A, B, ALUOut, all RF entries and isZero SHALL become 0, overriding all enables.
REQ-024 Reset mid-operation SHALL discard any pending write in that cycle; operation resumes next cycle from zero state.

Verification
REQ-025 After reset, jControl=0, PCWrite=1 one cycle -> PC_Out=0x0001.
REQ-026 IR<-0x0002, then jControl=1, PCWrite=1 -> PC_Out=0x0003.
REQ-027 toPC=1, Set_PC=0xABCD, PCWrite=1 -> PC_Out=0xABCD; then jControl=2, PCWrite=1 with IR=0x0002 -> PC_Out=0xA002.
REQ-028 IR=0x0078, Asel=0, Awrite -> A=0x0078; IR=0x0600, ItypeSel=0, Bsel=1, Bwrite -> B=0x0600; ALUcontrol=1, ALUOutWrite -> ALUOut=0x0678; jControl=3, PCWrite -> PC_Out=0x0678.
REQ-029 destData=5, destAddr=1, reg_write -> RF[1]=PC; then Asel=1, Awrite -> A == PC_Out (0x0678).
REQ-030 A=0x7FFF, B=0x0001, ALUcontrol=1 -> result 0x8000, overflow_out=1; ALUcontrol=2 with A=B -> iszero_write sets isZero=1.

Source files
------------

// File: rtl/processor_integration_5.sv
// Multicycle processor datapath: IR/MDR/A/B/ALUOut/PC registers, a 4-entry
// register file, an 8-function ALU with signed-overflow detect and a
// next-PC selector. Sequencing comes entirely from the external control inputs.
module processor_integration_5 (
   input  logic        Clock,
   input  logic        Reset,
   input  logic [15:0] Data_In,
   input  logic        IR_Write,
   input  logic [15:0] M_Data_In,
   input  logic        Mwrite,
   input  logic        Asel,
   input  logic        Bsel,
   input  logic        ItypeSel,
   input  logic        Awrite,
   input  logic        Bwrite,
   input  logic [2:0]  ALUcontrol,
   input  logic        ALUOutWrite,
   input  logic        iszero_write,
   input  logic        reg_write,
   input  logic [1:0]  destAddr,
   input  logic [2:0]  destData,
   input  logic [1:0]  jControl,
   input  logic        PCWrite,
   input  logic        toPC,
   input  logic [15:0] Set_PC,
   output logic [15:0] A,
   output logic [15:0] B,
   output logic [15:0] IR,
   output logic [15:0] ALUOut_output,
   output logic [15:0] PC_Out,
   output logic [15:0] PCData,
   output logic        isZero,
   output logic        overflow_out
);

   logic [15:0] ir_reg, mdr_reg, a_reg, b_reg, alu_out_reg, pc_reg;
   logic        is_zero_reg;
   logic [15:0] rf_reg [4];

   logic [15:0] imm, a_next, b_next, alu_result, wr_data, jump_target;
   logic [15:0] sum, diff;
   logic        overflow;

   // Immediate: upper-byte form or sign-extended 12-bit offset
   always_comb begin
      imm = ItypeSel ? {ir_reg[7:0], 8'h00} : {{4{ir_reg[11]}}, ir_reg[11:0]};
   end

   // Operand selection for the A and B latches (pre-edge RF contents)
   always_comb begin
      a_next = Asel ? rf_reg[destAddr] : imm;
      b_next = Bsel ? imm : rf_reg[ir_reg[11:10]];
   end

   // ALU and signed overflow; overflow only meaningful for ADD/SUB
   always_comb begin
      sum        = a_reg + b_reg;
      diff       = a_reg - b_reg;
      alu_result = '0;
      overflow   = 1'b0;
      case (ALUcontrol)
         3'd0: alu_result = a_reg & b_reg;
         3'd1: begin
            alu_result = sum;
            overflow   = (a_reg[15] == b_reg[15]) && (sum[15] != a_reg[15]);
         end
         3'd2: begin
            alu_result = diff;
            overflow   = (a_reg[15] != b_reg[15]) && (diff[15] != a_reg[15]);
         end
         3'd3: alu_result = a_reg | b_reg;
         3'd4: alu_result = a_reg ^ b_reg;
         3'd5: alu_result = a_reg << b_reg[3:0];
         3'd6: alu_result = a_reg >> b_reg[3:0];
         3'd7: alu_result = {15'b0, ($signed(a_reg) < $signed(b_reg))};
         default: alu_result = '0;
      endcase
   end

   // Register-file write-data selection
   always_comb begin
      wr_data = '0;
      case (destData)
         3'd0: wr_data = alu_out_reg;
         3'd1: wr_data = mdr_reg;
         3'd2: wr_data = imm;
         3'd3: wr_data = a_reg;
         3'd4: wr_data = b_reg;
         3'd5: wr_data = pc_reg;
         3'd6: wr_data = ir_reg;
         3'd7: wr_data = {15'b0, is_zero_reg};
         default: wr_data = '0;
      endcase
   end

   // Next-PC selection; toPC override takes priority over the jump mux
   always_comb begin
      jump_target = '0;
      case (jControl)
         2'd0: jump_target = pc_reg + 16'd1;
         2'd1: jump_target = pc_reg + {{4{ir_reg[11]}}, ir_reg[11:0]};
         2'd2: jump_target = {pc_reg[15:12], ir_reg[11:0]};
         2'd3: jump_target = alu_out_reg;
         default: jump_target = '0;
      endcase
      PCData = toPC ? Set_PC : jump_target;
   end

   // Datapath registers; reset (active low) overrides every load enable
   always_ff @(posedge Clock) begin
      if (!Reset) begin
         ir_reg      <= '0;
         mdr_reg     <= '0;
         a_reg       <= '0;
         b_reg       <= '0;
         alu_out_reg <= '0;
         pc_reg      <= '0;
         is_zero_reg <= 1'b0;
      end else begin
         if (IR_Write)     ir_reg      <= Data_In;
         if (Mwrite)       mdr_reg     <= M_Data_In;
         if (Awrite)       a_reg       <= a_next;
         if (Bwrite)       b_reg       <= b_next;
         if (ALUOutWrite)  alu_out_reg <= alu_result;
         if (iszero_write) is_zero_reg <= (alu_result == 16'd0);
         if (PCWrite)      pc_reg      <= PCData;
      end
   end

   // Register file: one entry per generate iteration, cleared on reset
   generate
      for (genvar gi = 0; gi < 4; gi++) begin : g_rf
         always_ff @(posedge Clock) begin
            if (!Reset)
               rf_reg[gi] <= '0;
            else if (reg_write && (destAddr == 2'(gi)))
               rf_reg[gi] <= wr_data;
         end
      end
   endgenerate

   assign A             = a_reg;
   assign B             = b_reg;
   assign IR            = ir_reg;
   assign ALUOut_output = alu_out_reg;
   assign PC_Out        = pc_reg;
   assign isZero        = is_zero_reg;
   assign overflow_out  = overflow;

endmodule

// File: tb/tb_processor_integration_5.sv
// Bench for processor_integration_5: arithmetic reference model updated each
// rising edge, per-cycle output comparison on the falling edge, and directed
// sequences with hand-computed literal expectations.
module tb_processor_integration_5;

   logic        Clock = 1'b0;
   logic        Reset;
   logic [15:0] Data_In, M_Data_In, Set_PC;
   logic        IR_Write, Mwrite, Asel, Bsel, ItypeSel, Awrite, Bwrite;
   logic [2:0]  ALUcontrol, destData;
   logic        ALUOutWrite, iszero_write, reg_write, PCWrite, toPC;
   logic [1:0]  destAddr, jControl;
   logic [15:0] A, B, IR, ALUOut_output, PC_Out, PCData;
   logic        isZero, overflow_out;

   int pass_cnt = 0;
   int tot_cnt  = 0;
   logic chk_en = 1'b0;

   always #5 Clock = ~Clock;

   processor_integration_5 dut (
      .Clock(Clock), .Reset(Reset), .Data_In(Data_In), .IR_Write(IR_Write),
      .M_Data_In(M_Data_In), .Mwrite(Mwrite), .Asel(Asel), .Bsel(Bsel),
      .ItypeSel(ItypeSel), .Awrite(Awrite), .Bwrite(Bwrite),
      .ALUcontrol(ALUcontrol), .ALUOutWrite(ALUOutWrite),
      .iszero_write(iszero_write), .reg_write(reg_write), .destAddr(destAddr),
      .destData(destData), .jControl(jControl), .PCWrite(PCWrite), .toPC(toPC),
      .Set_PC(Set_PC), .A(A), .B(B), .IR(IR), .ALUOut_output(ALUOut_output),
      .PC_Out(PC_Out), .PCData(PCData), .isZero(isZero),
      .overflow_out(overflow_out)
   );

   // ---------------- reference model (plain integer arithmetic) ----------
   logic [15:0] m_ir, m_mdr, m_a, m_b, m_alu, m_pc;
   logic        m_z;
   logic [15:0] m_rf [4];

   function automatic logic [15:0] f_imm(input logic [15:0] ir, input logic itype);
      int v;
      if (itype) return 16'((int'(ir) % 256) * 256);
      v = int'(ir) % 4096;
      if (v >= 2048) v -= 4096;
      return 16'(v);
   endfunction

   function automatic logic [15:0] f_alu(input logic [15:0] a, input logic [15:0] b,
                                         input logic [2:0] op);
      longint ua, ub;
      int sa, sb;
      ua = longint'(a); ub = longint'(b);
      sa = $signed(a);  sb = $signed(b);
      case (op)
         3'd0: return a & b;
         3'd1: return 16'(ua + ub);
         3'd2: return 16'(ua - ub);
         3'd3: return a | b;
         3'd4: return a ^ b;
         3'd5: return 16'(ua * (longint'(1) << (ub % 16)));
         3'd6: return 16'(ua / (longint'(1) << (ub % 16)));
         default: return (sa < sb) ? 16'd1 : 16'd0;
      endcase
   endfunction

   function automatic logic f_ovf(input logic [15:0] a, input logic [15:0] b,
                                  input logic [2:0] op);
      int s;
      if (op == 3'd1) s = int'($signed(a)) + int'($signed(b));
      else if (op == 3'd2) s = int'($signed(a)) - int'($signed(b));
      else return 1'b0;
      return (s > 32767) || (s < -32768);
   endfunction

   function automatic logic [15:0] f_pcdata(input logic [15:0] pc, input logic [15:0] ir,
                                            input logic [15:0] aluout, input logic [1:0] j,
                                            input logic topc, input logic [15:0] setpc);
      if (topc) return setpc;
      case (j)
         2'd0: return 16'(int'(pc) + 1);
         2'd1: return 16'(int'(pc) + int'($signed(f_imm(ir, 1'b0))));
         2'd2: return 16'((int'(pc) / 4096) * 4096 + int'(ir) % 4096);
         default: return aluout;
      endcase
   endfunction

   // Model state advance on every rising edge from the applied controls
   always @(posedge Clock) begin
      logic [15:0] imm, res, wd, n_ir, n_mdr, n_a, n_b, n_alu, n_pc;
      logic        n_z;
      if (!Reset) begin
         m_ir = 0; m_mdr = 0; m_a = 0; m_b = 0; m_alu = 0; m_pc = 0; m_z = 0;
         for (int i = 0; i < 4; i++) m_rf[i] = 0;
      end else begin
         imm = f_imm(m_ir, ItypeSel);
         res = f_alu(m_a, m_b, ALUcontrol);
         case (destData)
            3'd0: wd = m_alu;
            3'd1: wd = m_mdr;
            3'd2: wd = imm;
            3'd3: wd = m_a;
            3'd4: wd = m_b;
            3'd5: wd = m_pc;
            3'd6: wd = m_ir;
            default: wd = 16'(m_z);
         endcase
         n_ir  = IR_Write ? Data_In : m_ir;
         n_mdr = Mwrite ? M_Data_In : m_mdr;
         n_a   = Awrite ? (Asel ? m_rf[destAddr] : imm) : m_a;
         n_b   = Bwrite ? (Bsel ? imm : m_rf[int'(m_ir) / 1024 % 4]) : m_b;
         n_alu = ALUOutWrite ? res : m_alu;
         n_z   = iszero_write ? (res == 0) : m_z;
         n_pc  = PCWrite ? f_pcdata(m_pc, m_ir, m_alu, jControl, toPC, Set_PC) : m_pc;
         if (reg_write) m_rf[destAddr] = wd;
         m_ir = n_ir; m_mdr = n_mdr; m_a = n_a; m_b = n_b;
         m_alu = n_alu; m_z = n_z; m_pc = n_pc;
      end
   end

   task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
      tot_cnt++;
      if (act === exp) pass_cnt++;
      else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
   endtask

   // Per-cycle comparison of every output against the model
   always @(negedge Clock) begin
      if (chk_en) begin
         check("A", A, m_a);
         check("B", B, m_b);
         check("IR", IR, m_ir);
         check("ALUOut", ALUOut_output, m_alu);
         check("PC_Out", PC_Out, m_pc);
         check("isZero", 16'(isZero), 16'(m_z));
         check("PCData", PCData, f_pcdata(m_pc, m_ir, m_alu, jControl, toPC, Set_PC));
         check("overflow", 16'(overflow_out), 16'(f_ovf(m_a, m_b, ALUcontrol)));
      end
   end

   // ---------------- stimulus ----------------
   task automatic tick();
      @(posedge Clock);
      #1;
   endtask

   task automatic idle();
      Reset = 1; Data_In = 0; M_Data_In = 0; Set_PC = 0;
      IR_Write = 0; Mwrite = 0; Asel = 0; Bsel = 0; ItypeSel = 0;
      Awrite = 0; Bwrite = 0; ALUcontrol = 0; ALUOutWrite = 0;
      iszero_write = 0; reg_write = 0; destAddr = 0; destData = 0;
      jControl = 0; PCWrite = 0; toPC = 0;
   endtask

   // Puts a into RF[0]/A and b into RF[3]/B via the IR write-back path
   task automatic load_ab(input logic [15:0] a, input logic [15:0] b);
      idle(); Data_In = a; IR_Write = 1; tick();
      idle(); destData = 6; destAddr = 0; reg_write = 1; tick();
      idle(); Data_In = b; IR_Write = 1; tick();
      idle(); destData = 6; destAddr = 3; reg_write = 1; tick();
      idle(); Data_In = 16'h0C00; IR_Write = 1; tick();
      idle(); Asel = 1; destAddr = 0; Awrite = 1; Bsel = 0; Bwrite = 1; tick();
      idle();
   endtask

   logic [15:0] tbl_a [4] = '{16'h1234, 16'hFFFF, 16'h8000, 16'h00F0};
   logic [15:0] tbl_b [4] = '{16'h0F0F, 16'h0001, 16'h8000, 16'h0004};

   initial begin
      // Reset with enables asserted: reset must win
      idle(); Reset = 0; PCWrite = 1; reg_write = 1; Awrite = 1;
      IR_Write = 1; Data_In = 16'h1234; tick(); tick();
      chk_en = 1;
      check("rst_pc", PC_Out, 16'h0000);
      check("rst_ir", IR, 16'h0000);
      check("rst_a", A, 16'h0000);

      idle(); PCWrite = 1; tick();
      check("pc_inc", PC_Out, 16'h0001);
      idle(); Data_In = 16'h0002; IR_Write = 1; tick();
      idle(); jControl = 1; PCWrite = 1; tick();
      check("pc_rel", PC_Out, 16'h0003);
      idle(); toPC = 1; Set_PC = 16'hABCD; tick();
      check("topc_nowrite", PC_Out, 16'h0003);
      idle(); toPC = 1; Set_PC = 16'hABCD; PCWrite = 1; tick();
      check("topc", PC_Out, 16'hABCD);
      idle(); jControl = 2; PCWrite = 1; tick();
      check("pc_abs", PC_Out, 16'hA002);

      idle(); Data_In = 16'h0078; IR_Write = 1; tick();
      idle(); Awrite = 1; tick();
      check("a_imm", A, 16'h0078);
      idle(); Data_In = 16'h0600; IR_Write = 1; tick();
      idle(); Bsel = 1; Bwrite = 1; tick();
      check("b_imm", B, 16'h0600);
      idle(); ALUcontrol = 1; ALUOutWrite = 1; tick();
      check("alu_add", ALUOut_output, 16'h0678);
      idle(); jControl = 3; PCWrite = 1; tick();
      check("pc_alu", PC_Out, 16'h0678);

      idle(); destData = 5; destAddr = 1; reg_write = 1; tick();
      idle(); Asel = 1; destAddr = 1; Awrite = 1; tick();
      check("a_rf_pc", A, 16'h0678);
      idle(); destData = 2; destAddr = 1; reg_write = 1; Asel = 1; Awrite = 1; tick();
      check("a_old_rf", A, 16'h0678);
      idle(); Asel = 1; destAddr = 1; Awrite = 1; tick();
      check("a_new_rf", A, 16'h0600);

      idle(); Data_In = 16'h0F85; IR_Write = 1; tick();
      idle(); ItypeSel = 1; Awrite = 1; tick();
      check("imm_upper", A, 16'h8500);
      idle(); Bsel = 1; Bwrite = 1; tick();
      check("imm_sext", B, 16'hFF85);

      idle(); M_Data_In = 16'hBEEF; Mwrite = 1; tick();
      idle(); destData = 1; destAddr = 2; reg_write = 1; tick();
      idle(); Asel = 1; destAddr = 2; Awrite = 1; tick();
      check("mdr_path", A, 16'hBEEF);

      load_ab(16'h7FFF, 16'h0001);
      ALUcontrol = 1; #1;
      check("ovf_add", 16'(overflow_out), 16'h0001);
      ALUOutWrite = 1; tick();
      check("add_wrap", ALUOut_output, 16'h8000);
      load_ab(16'h7FFF, 16'h7FFF);
      ALUcontrol = 2; iszero_write = 1; tick();
      check("zero_set", 16'(isZero), 16'h0001);
      check("ovf_sub", 16'(overflow_out), 16'h0000);
      idle(); destData = 7; destAddr = 2; reg_write = 1; tick();
      idle(); Asel = 1; destAddr = 2; Awrite = 1; tick();
      check("rf_zero_flag", A, 16'h0001);

      for (int p = 0; p < 4; p++) begin
         load_ab(tbl_a[p], tbl_b[p]);
         for (int op = 0; op < 8; op++) begin
            idle(); ALUcontrol = 3'(op); ALUOutWrite = 1; iszero_write = 1; tick();
         end
      end
      load_ab(16'h8000, 16'h0001);
      ALUcontrol = 7; ALUOutWrite = 1; tick();
      check("slt_neg", ALUOut_output, 16'h0001);
      idle(); ALUcontrol = 6; ALUOutWrite = 1; tick();
      check("srl", ALUOut_output, 16'h4000);
      idle(); ALUcontrol = 5; ALUOutWrite = 1; iszero_write = 1; tick();
      check("sll_out", ALUOut_output, 16'h0000);
      check("sll_zero", 16'(isZero), 16'h0001);

      idle(); toPC = 1; Set_PC = 16'hFFFF; PCWrite = 1; tick();
      idle(); PCWrite = 1; tick();
      check("pc_wrap", PC_Out, 16'h0000);
      idle(); Data_In = 16'h0FFF; IR_Write = 1; tick();
      idle(); jControl = 1; PCWrite = 1; tick();
      check("pc_neg_off", PC_Out, 16'hFFFF);

      idle(); Reset = 0; PCWrite = 1; reg_write = 1; destData = 5; Awrite = 1;
      ALUOutWrite = 1; iszero_write = 1; IR_Write = 1; Data_In = 16'h5555; tick();
      check("midrst_pc", PC_Out, 16'h0000);
      check("midrst_ir", IR, 16'h0000);
      check("midrst_z", 16'(isZero), 16'h0000);
      idle(); PCWrite = 1; tick();
      check("resume_pc", PC_Out, 16'h0001);
      idle(); Asel = 1; destAddr = 1; Awrite = 1; tick();
      check("midrst_rf", A, 16'h0000);

      @(negedge Clock);
      #1;
      $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
      $finish;
   end

endmodule
